// File: rtl/param_pipelined_alu.sv
// Three-stage valid/ready ALU pipeline: S1 operands, S2 computed values, S3 registered outputs.
// Define ALU_TAG_EN to carry a TAG_W-bit transaction tag alongside each operation.
module param_pipelined_alu #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2:0]           op,
`ifdef ALU_TAG_EN
  input  logic [TAG_W-1:0]     in_tag,
  output logic [TAG_W-1:0]     out_tag,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result,
  output logic                 zero,
  output logic                 carry
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_MUL = 3'b010,
    OP_AND = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  logic               advance;
  logic               s1_valid, s2_valid;
  logic [WIDTH-1:0]   s1_a, s1_b;
  op_e                s1_op;
  logic [2*WIDTH-1:0] s2_result;
  logic               s2_carry;
  logic [2*WIDTH-1:0] calc_result;
  logic               calc_carry;
  logic [WIDTH:0]     sum_ext, diff_ext;
  logic [2*WIDTH-1:0] a_ext, b_ext;
  logic [SHW-1:0]     shamt;

  // One global stall: the whole pipeline moves only when the output slot frees up.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  assign sum_ext  = {1'b0, s1_a} + {1'b0, s1_b};
  assign diff_ext = {1'b0, s1_a} - {1'b0, s1_b};
  assign a_ext    = {{WIDTH{1'b0}}, s1_a};
  assign b_ext    = {{WIDTH{1'b0}}, s1_b};
  assign shamt    = s1_b[SHW-1:0];

  // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    calc_result = '0;
    calc_carry  = 1'b0;
    case (s1_op)
      OP_ADD: begin
        calc_result = {{(WIDTH-1){1'b0}}, sum_ext};
        calc_carry  = sum_ext[WIDTH];
      end
      OP_SUB: begin
        calc_result = {{(WIDTH-1){1'b0}}, diff_ext};
        calc_carry  = diff_ext[WIDTH];
      end
      OP_MUL: calc_result = a_ext * b_ext;
      OP_AND: calc_result = a_ext & b_ext;
      OP_OR:  calc_result = a_ext | b_ext;
      OP_XOR: calc_result = a_ext ^ b_ext;
      OP_SHL: calc_result = a_ext << shamt;
      OP_SHR: calc_result = a_ext >> shamt;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: datapath registers are cleared too, so outputs read 0 right after reset.
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_op     <= OP_ADD;
      s2_valid  <= 1'b0;
      s2_result <= '0;
      s2_carry  <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      carry     <= 1'b0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_a      <= a;
      s1_b      <= b;
      s1_op     <= op_e'(op);
      s2_valid  <= s1_valid;
      s2_result <= calc_result;
      s2_carry  <= calc_carry;
      out_valid <= s2_valid;
      result    <= s2_result;
      zero      <= (s2_result == '0);
      carry     <= s2_carry;
    end
  end

`ifdef ALU_TAG_EN
  logic [TAG_W-1:0] s1_tag, s2_tag;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_tag  <= '0;
      s2_tag  <= '0;
      out_tag <= '0;
    end else if (advance) begin
      s1_tag  <= in_tag;
      s2_tag  <= s1_tag;
      out_tag <= s2_tag;
    end
  end
`endif

endmodule

// File: tb/tb_param_pipelined_alu.sv
// Self-checking bench for param_pipelined_alu (WIDTH=8): vector table, random stream with
// backpressure, stall/reset corner sequences; results checked through an expectation queue.
module tb_param_pipelined_alu;

  localparam int WIDTH = 8;
  localparam int TAG_W = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   a, b;
  logic [2:0]   op;
  logic         out_valid;
  logic         out_ready;
  logic [15:0]  result;
  logic         zero;
  logic         carry;
`ifdef ALU_TAG_EN
  logic [3:0]   in_tag, out_tag;
`endif

  param_pipelined_alu #(.WIDTH(WIDTH), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
`ifdef ALU_TAG_EN
    .in_tag    (in_tag),
    .out_tag   (out_tag),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] result;
    logic        zero;
    logic        carry;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] res;
    logic        c;
    logic        z;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  exp_t none = '{16'h0, 1'b0, 1'b0, 4'h0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [7:0] ai, input logic [7:0] bi,
                                 input logic [2:0] oi, input logic [3:0] ti);
    int   x, y, r;
    logic c;
    exp_t e;
    x = int'(ai);
    y = int'(bi);
    c = 1'b0;
    case (oi)
      3'd0: begin r = x + y; c = (r > 255); end
      3'd1: begin c = (x < y); r = (x - y + 512) % 512; end
      3'd2: r = x * y;
      3'd3: r = x & y;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = x << (y % 8);
      default: r = x >> (y % 8);
    endcase
    e.result = r[15:0];
    e.zero   = (r == 0);
    e.carry  = c;
    e.tag    = ti;
    return e;
  endfunction

  // Inputs are already set at the falling edge; record accepted stimulus, retire delivered results.
  task automatic cycle(input exp_t e);
    exp_t got;
    #1;
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(e);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", 32'(result), 32'hFFFF_FFFF);
        end else begin
          got = sb.pop_front();
          check("result", 32'(result), 32'(got.result));
          check("zero",   32'(zero),   32'(got.zero));
          check("carry",  32'(carry),  32'(got.carry));
`ifdef ALU_TAG_EN
          check("out_tag", 32'(out_tag), 32'(got.tag));
`endif
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic issue(input logic v, input logic [7:0] ai, input logic [7:0] bi,
                       input logic [2:0] oi, input exp_t e);
    in_valid = v;
    a        = ai;
    b        = bi;
    op       = oi;
`ifdef ALU_TAG_EN
    in_tag   = e.tag;
`endif
    cycle(e);
  endtask

  task automatic drain();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycle(none);
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  vec_t vecs[11];

  initial begin
    vecs[0]  = '{3'd0, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 8'd5,   8'd20,  16'h01F1, 1'b1, 1'b0};
    vecs[2]  = '{3'd1, 8'd7,   8'd7,   16'h0000, 1'b0, 1'b1};
    vecs[3]  = '{3'd2, 8'd255, 8'd255, 16'hFE01, 1'b0, 1'b0};
    vecs[4]  = '{3'd6, 8'h81,  8'd9,   16'h0102, 1'b0, 1'b0};
    vecs[5]  = '{3'd7, 8'h80,  8'd7,   16'h0001, 1'b0, 1'b0};
    vecs[6]  = '{3'd0, 8'd255, 8'd1,   16'h0100, 1'b1, 1'b0};
    vecs[7]  = '{3'd3, 8'hF0,  8'h0F,  16'h0000, 1'b0, 1'b1};
    vecs[8]  = '{3'd6, 8'hFF,  8'd7,   16'h7F80, 1'b0, 1'b0};
    vecs[9]  = '{3'd1, 8'd20,  8'd5,   16'h000F, 1'b0, 1'b0};
    vecs[10] = '{3'd7, 8'h80,  8'd8,   16'h0080, 1'b0, 1'b0};

    reset     = 1'b1;
    in_valid  = 1'b1;
    a         = 8'd1;
    b         = 8'd1;
    op        = 3'd0;
    out_ready = 1'b1;
`ifdef ALU_TAG_EN
    in_tag    = 4'hF;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    32'(result),    32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_carry",     32'(carry),     32'd0);
`ifdef ALU_TAG_EN
    check("rst_out_tag",   32'(out_tag),   32'd0);
`endif
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 32'd1);

    // Latency: accepted at edge k, out_valid only after edge k+2.
    issue(1'b1, 8'd200, 8'd100, 3'd0, model(8'd200, 8'd100, 3'd0, 4'd1));
    check("lat_k", 32'(out_valid), 32'd0);
    issue(1'b0, 8'd0, 8'd0, 3'd0, none);
    check("lat_k1", 32'(out_valid), 32'd0);
    issue(1'b0, 8'd0, 8'd0, 3'd0, none);
    check("lat_k2", 32'(out_valid), 32'd1);
    drain();

    // Table vectors back to back.
    for (int i = 0; i < 11; i++)
      issue(1'b1, vecs[i].a, vecs[i].b, vecs[i].op,
            '{vecs[i].res, vecs[i].z, vecs[i].c, 4'(i)});
    drain();

    // Random stream with random bubbles and backpressure.
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic [2:0] ro;
      logic [3:0] rt;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 3'($urandom);
      rt = 4'($urandom);
      out_ready = ($urandom_range(0, 9) < 7);
      issue(($urandom_range(0, 9) < 7), ra, rb, ro, model(ra, rb, ro, rt));
    end
    drain();

    // Stall: XOR, AND, OR back to back, consumer stalls 3 cycles on the first result.
    issue(1'b1, 8'hAA, 8'hCC, 3'd5, '{16'h0066, 1'b0, 1'b0, 4'd2});
    issue(1'b1, 8'hAA, 8'hCC, 3'd3, '{16'h0088, 1'b0, 1'b0, 4'd4});
    issue(1'b1, 8'hAA, 8'hCC, 3'd4, '{16'h00EE, 1'b0, 1'b0, 4'd6});
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_in_ready",  32'(in_ready),  32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      check("stall_result",    32'(result),    32'h0066);
      cycle(none);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("post_stall_consecutive", 32'(out_valid), 32'd1);
      cycle(none);
    end
    check("post_stall_empty", 32'(sb.size()), 32'd0);

    // Reset mid-stream: in-flight ops and in_valid during reset must vanish.
    issue(1'b1, 8'd3, 8'd4, 3'd0, model(8'd3, 8'd4, 3'd0, 4'd7));
    issue(1'b1, 8'd9, 8'd2, 3'd2, model(8'd9, 8'd2, 3'd2, 4'd8));
    reset = 1'b1;
    sb.delete();
    issue(1'b1, 8'd50, 8'd50, 3'd0, none);
    reset    = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready",  32'(in_ready),  32'd1);
    check("midrst_result",    32'(result),    32'd0);
    issue(1'b1, 8'd1, 8'd1, 3'd0, '{16'h0002, 1'b0, 1'b0, 4'd1});
    drain();
    for (int i = 0; i < 6; i++) issue(1'b0, 8'd0, 8'd0, 3'd0, none);

`ifdef ALU_TAG_EN
    // Tags with mixed bubbles stay aligned with their results.
    issue(1'b1, 8'd1, 8'd2, 3'd0, model(8'd1, 8'd2, 3'd0, 4'd3));
    issue(1'b0, 8'd0, 8'd0, 3'd0, none);
    issue(1'b1, 8'd6, 8'd7, 3'd2, model(8'd6, 8'd7, 3'd2, 4'd9));
    issue(1'b0, 8'd0, 8'd0, 3'd0, none);
    issue(1'b0, 8'd0, 8'd0, 3'd0, none);
    issue(1'b1, 8'h0F, 8'h3C, 3'd5, model(8'h0F, 8'h3C, 3'd5, 4'd5));
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
